fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Portable, parametrised single-clock FIFO. Replaces vendor XPM sync FIFOs in the event-processing datapath, e.g. buffering neighbour/feature words between graph-build and conv stages.
- Adds selectable standard or first-word-fall-through read mode, runtime flush, programmable thresholds, an occupancy count and sticky-free status pulses.
- Synthesises to inferred RAM, so the same RTL runs in simulation and on ASIC/FPGA flows.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 2048, number of entries; power of two, >=4
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through
PROG_FULL_THRESH, 10, prog_full asserted when count >= this (1..DEPTH)
PROG_EMPTY_THRESH, 10, prog_empty asserted when count <= this (0..DEPTH-1)
DOUT_RESET, 0, value of dout after rst/clr (standard mode)
(localparam CNT_W = $clog2(DEPTH)+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  synchronous flush; same effect as rst on FIFO state
wr_en  in  1  write request
din  in  WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= DEPTH-1
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected (full)
rd_en  in  1  read request (std) / pop (fwft)
dout  out  WIDTH  read data
data_valid  out  1  dout holds a valid word
empty  out  1  count == 0
almost_empty  out  1  count <= 1
underflow  out  1  previous-cycle read rejected (empty)
count  out  CNT_W  words currently stored
prog_full  out  1  count >= PROG_FULL_THRESH
prog_empty  out  1  count <= PROG_EMPTY_THRESH

Behaviour:
- Reset and flush:
  - rst or clr sampled high: wr_ptr = rd_ptr = 0, count = 0, dout = DOUT_RESET, wr_ack = overflow = underflow = data_valid = 0.
  - Hence empty = almost_empty = prog_empty = 1 and full = almost_full = prog_full = 0 from the next cycle.
  - wr_en/rd_en in the same cycle as rst/clr are ignored and do not raise overflow/underflow.
  - Memory contents are not cleared.
- Write accept: wr_en && !full. Writes mem[wr_ptr] <= din, wr_ptr increments and wraps modulo DEPTH. wr_ack = 1 next cycle.
- Write reject: wr_en && full. Memory unchanged; overflow = 1 for exactly the next cycle.
  - A write is rejected when full even if a read is accepted in the same cycle.
- Read accept: rd_en && !empty. rd_ptr increments and wraps modulo DEPTH.
- Read reject: rd_en && empty. underflow = 1 for the next cycle; dout and data_valid hold their previous values.
  - A read is rejected when empty even if a write is accepted in the same cycle; no bypass.
- Standard mode (FWFT = 0):
  - dout registered: dout <= mem[rd_ptr] on accepted read, else holds.
  - data_valid = 1 for exactly the cycle after an accepted read.
  - Read latency is 1 cycle.
- FWFT mode (FWFT = 1):
  - dout = mem[rd_ptr] whenever !empty; data_valid = !empty.
  - rd_en acts as an acknowledge and the next word appears the following cycle.
  - A word written at edge N is visible on dout from cycle N+1, when empty deasserts.
- count:
  - +1 on accept-write only, -1 on accept-read only, unchanged when both are accepted.
  - Never exceeds DEPTH and never goes below 0.
  - All flags are decoded from the registered count (and registered ptrs), so flags change the cycle after the operation that causes the change.
- Pointer wrap: data order is preserved across wrap. Full/empty are resolved by count, not by pointer equality.

Test Plan:
(bench uses DEPTH=16, WIDTH=32, PROG_FULL_THRESH=12, PROG_EMPTY_THRESH=2)
- Fill/drain, std mode: reset, write 1..16 back-to-back.
  - Cycle after the 16th write: full = 1, count = 16, prog_full = 1.
  - Read 16 times: dout sequence 1..16, each one cycle after its rd_en; data_valid pulses track the reads; then empty = 1.
- Overflow/underflow:
  - With full = 1, assert wr_en with din = 0xDEAD: overflow = 1 for one cycle, count stays 16, drained data contains no 0xDEAD.
  - With empty = 1, assert rd_en: underflow = 1 for one cycle, dout unchanged.
- Simultaneous read and write:
  - At count = 5, assert both for 20 cycles with an incrementing din: count stays 5 and output order is strictly monotonic across pointer wrap.
  - At full, the same stimulus gives count = 15 the next cycle.
- FWFT mode: write 0xA5 into an empty FIFO.
  - Next cycle: empty = 0, data_valid = 1, dout = 0xA5 with no rd_en.
  - Pop: empty = 1 the following cycle.
- Flush mid-operation: at count = 9, assert clr together with wr_en and rd_en.
  - Next cycle: count = 0, empty = 1, wr_ack = overflow = underflow = 0, dout = DOUT_RESET.
  - A subsequent write/read returns the new word.
- Thresholds: fill one word at a time and check:
  - prog_empty deasserts at count = 3.
  - almost_empty deasserts at count = 2.
  - prog_full asserts at count = 12.
  - almost_full asserts at count = 15.
  - Each flag changes the cycle after its causing write.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// synchronous flush, programmable thresholds and an occupancy count.
module fifo_sync_param #(
    parameter int              WIDTH             = 32,
    parameter int              DEPTH             = 2048,
    parameter int              FWFT              = 0,
    parameter int              PROG_FULL_THRESH  = 10,
    parameter int              PROG_EMPTY_THRESH = 10,
    parameter logic [WIDTH-1:0] DOUT_RESET       = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    output logic                     wr_ack,
    output logic                     overflow,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     data_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     prog_full,
    output logic                     prog_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             wr_ack_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic [WIDTH-1:0] dout_reg;

    logic flush;
    logic is_full;
    logic is_empty;
    logic wr_acc;
    logic rd_acc;

    // Full/empty come from the count so pointer equality never has to be disambiguated.
    assign flush    = rst | clr;
    assign is_full  = (count_reg == CNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);
    assign wr_acc   = wr_en && !is_full  && !flush;
    assign rd_acc   = rd_en && !is_empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            wr_ack_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            wr_ack_reg    <= wr_acc;
            overflow_reg  <= wr_en && is_full;
            underflow_reg <= rd_en && is_empty;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic data_valid_reg;

            always_ff @(posedge clk) begin
                if (flush) begin
                    dout_reg       <= DOUT_RESET;
                    data_valid_reg <= 1'b0;
                end else begin
                    data_valid_reg <= rd_acc;
                    if (rd_acc) begin
                        dout_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign data_valid = data_valid_reg;
        end else begin : g_fwft
            logic [AW-1:0] rd_ptr_next;

            // Prefetch the head for the next cycle; a write landing on that slot
            // is forwarded so the registered read still sees it one cycle later.
            assign rd_ptr_next = rd_ptr_reg + AW'(rd_acc);

            always_ff @(posedge clk) begin
                if (flush) begin
                    dout_reg <= DOUT_RESET;
                end else if (wr_acc && (wr_ptr_reg == rd_ptr_next)) begin
                    dout_reg <= din;
                end else begin
                    dout_reg <= mem[rd_ptr_next];
                end
            end

            assign data_valid = !is_empty;
        end
    endgenerate

    assign dout         = dout_reg;
    assign count        = count_reg;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_reg >= CNT_W'(DEPTH - 1));
    assign almost_empty = (count_reg <= CNT_W'(1));
    assign prog_full    = (count_reg >= CNT_W'(PROG_FULL_THRESH));
    assign prog_empty   = (count_reg <= CNT_W'(PROG_EMPTY_THRESH));
    assign wr_ack       = wr_ack_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: a standard-mode and an FWFT-mode FIFO (DEPTH=16) driven by
// directed vectors; read data is checked by a monitor against queued expectations.
module tb_fifo_sync_param;

    localparam int          W     = 32;
    localparam int          D     = 16;
    localparam logic [31:0] DRST  = 32'h5555_AAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // standard-mode DUT
    logic        s_clr, s_wr_en, s_rd_en;
    logic [31:0] s_din, s_dout;
    logic        s_full, s_almost_full, s_wr_ack, s_overflow, s_data_valid;
    logic        s_empty, s_almost_empty, s_underflow, s_prog_full, s_prog_empty;
    logic [4:0]  s_count;

    // FWFT-mode DUT
    logic        f_clr, f_wr_en, f_rd_en;
    logic [31:0] f_din, f_dout;
    logic        f_full, f_almost_full, f_wr_ack, f_overflow, f_data_valid;
    logic        f_empty, f_almost_empty, f_underflow, f_prog_full, f_prog_empty;
    logic [4:0]  f_count;

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(0), .PROG_FULL_THRESH(12),
                      .PROG_EMPTY_THRESH(2), .DOUT_RESET(DRST)) u_std (
        .clk(clk), .rst(rst), .clr(s_clr), .wr_en(s_wr_en), .din(s_din),
        .full(s_full), .almost_full(s_almost_full), .wr_ack(s_wr_ack),
        .overflow(s_overflow), .rd_en(s_rd_en), .dout(s_dout),
        .data_valid(s_data_valid), .empty(s_empty), .almost_empty(s_almost_empty),
        .underflow(s_underflow), .count(s_count), .prog_full(s_prog_full),
        .prog_empty(s_prog_empty)
    );

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1), .PROG_FULL_THRESH(12),
                      .PROG_EMPTY_THRESH(2), .DOUT_RESET(DRST)) u_fwft (
        .clk(clk), .rst(rst), .clr(f_clr), .wr_en(f_wr_en), .din(f_din),
        .full(f_full), .almost_full(f_almost_full), .wr_ack(f_wr_ack),
        .overflow(f_overflow), .rd_en(f_rd_en), .dout(f_dout),
        .data_valid(f_data_valid), .empty(f_empty), .almost_empty(f_almost_empty),
        .underflow(f_underflow), .count(f_count), .prog_full(f_prog_full),
        .prog_empty(f_prog_empty)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          stim_done = 1'b0;
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One std-mode cycle; the model decides acceptance from its own occupancy.
    task automatic do_cycle(input logic we, input logic [31:0] d, input logic re);
        bit wa, ra;
        wa = we && (model_q.size() < D);
        ra = re && (model_q.size() > 0);
        s_wr_en = we;
        s_din   = d;
        s_rd_en = re;
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        tick();
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;
        check("wr_ack",     s_wr_ack,     wa);
        check("overflow",   s_overflow,   we && !wa);
        check("underflow",  s_underflow,  re && !ra);
        check("data_valid", s_data_valid, ra);
        check("count",      s_count,      model_q.size());
    endtask

    task automatic run_monitor();
        while (!stim_done) begin
            @(negedge clk);
            if (s_data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", s_dout, 32'hFFFF_FFFF);
                end else begin
                    check("dout", s_dout, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic run_stimulus();
        rst = 1'b1;
        s_clr = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_din = '0;
        f_clr = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_empty",        s_empty,        1'b1);
        check("rst_almost_empty", s_almost_empty, 1'b1);
        check("rst_prog_empty",   s_prog_empty,   1'b1);
        check("rst_full",         s_full,         1'b0);
        check("rst_almost_full",  s_almost_full,  1'b0);
        check("rst_prog_full",    s_prog_full,    1'b0);
        check("rst_count",        s_count,        32'd0);
        check("rst_dout",         s_dout,         DRST);
        check("rst_data_valid",   s_data_valid,   1'b0);
        check("rst_fwft_empty",   f_empty,        1'b1);

        // fill one word at a time, thresholds follow the cycle after each write
        for (int i = 1; i <= 16; i++) begin
            do_cycle(1'b1, 32'(i), 1'b0);
            check("prog_empty",   s_prog_empty,   (i <= 2));
            check("almost_empty", s_almost_empty, (i <= 1));
            check("prog_full",    s_prog_full,    (i >= 12));
            check("almost_full",  s_almost_full,  (i >= 15));
            check("full",         s_full,         (i == 16));
        end
        check("full_count", s_count, 32'd16);

        // write while full: overflow for exactly one cycle
        do_cycle(1'b1, 32'h0000_DEAD, 1'b0);
        check("ovf_count", s_count, 32'd16);
        do_cycle(1'b0, 32'h0, 1'b0);
        check("ovf_clears", s_overflow, 1'b0);

        for (int i = 1; i <= 16; i++) do_cycle(1'b0, 32'h0, 1'b1);
        check("drained_empty", s_empty, 1'b1);
        check("last_dout",     s_dout,  32'd16);

        // read while empty: underflow pulse, dout keeps the last word
        do_cycle(1'b0, 32'h0, 1'b1);
        check("unf_dout", s_dout, 32'd16);
        do_cycle(1'b0, 32'h0, 1'b0);
        check("unf_clears", s_underflow, 1'b0);

        // concurrent read/write at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 32'(100 + i), 1'b0);
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 32'(105 + i), 1'b1);
        check("rw_count", s_count, 32'd5);

        for (int i = 0; i < 11; i++) do_cycle(1'b1, 32'(200 + i), 1'b0);
        check("refill_full", s_full, 1'b1);
        do_cycle(1'b1, 32'h0000_BEEF, 1'b1);
        check("rw_at_full_count", s_count, 32'd15);

        for (int i = 0; i < 6; i++) do_cycle(1'b0, 32'h0, 1'b1);
        check("pre_flush_count", s_count, 32'd9);

        // flush with simultaneous requests
        s_clr = 1'b1; s_wr_en = 1'b1; s_rd_en = 1'b1; s_din = 32'h0000_0BAD;
        model_q.delete();
        tick();
        s_clr = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        check("clr_count",      s_count,      32'd0);
        check("clr_empty",      s_empty,      1'b1);
        check("clr_wr_ack",     s_wr_ack,     1'b0);
        check("clr_overflow",   s_overflow,   1'b0);
        check("clr_underflow",  s_underflow,  1'b0);
        check("clr_data_valid", s_data_valid, 1'b0);
        check("clr_dout",       s_dout,       DRST);
        do_cycle(1'b1, 32'h0000_0077, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b1);
        check("post_clr_dout", s_dout, 32'h0000_0077);

        // FWFT: word visible without rd_en, pop empties
        f_wr_en = 1'b1; f_din = 32'h0000_00A5;
        tick();
        f_wr_en = 1'b0;
        check("fw_empty",      f_empty,      1'b0);
        check("fw_data_valid", f_data_valid, 1'b1);
        check("fw_dout",       f_dout,       32'h0000_00A5);
        tick();
        check("fw_dout_hold",  f_dout,       32'h0000_00A5);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fw_pop_empty",  f_empty,      1'b1);
        check("fw_pop_valid",  f_data_valid, 1'b0);

        f_wr_en = 1'b1; f_din = 32'h0000_0011;
        tick();
        f_din = 32'h0000_0022;
        tick();
        f_wr_en = 1'b0;
        check("fw_head1",  f_dout,  32'h0000_0011);
        check("fw_count2", f_count, 32'd2);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fw_head2",  f_dout,  32'h0000_0022);
        check("fw_count1", f_count, 32'd1);

        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        stim_done = 1'b1;
    endtask

    initial begin
        fork
            run_monitor();
            run_stimulus();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
